hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 142 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use and HI/LO interlocks, branch flush, MDU occupancy, syscall halt.
// Optional statistics counters are built only when HAZARD_STATS_EN is defined.
module hazard_ctrl #(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 32
) (
    input  logic        clk,
    input  logic        CLR,
    input  logic [4:0]  rs_id,
    input  logic [4:0]  rt_id,
    input  logic        use_rs,
    input  logic        use_rt,
    input  logic        hilo_id,
    input  logic        RegWrite_ex,
    input  logic        MemtoReg_ex,
    input  logic [4:0]  WbRegNum_ex,
    input  logic        bj_taken,
    input  logic        mdu_start,
    input  logic        mdu_div,
    input  logic        SYSCALL_wb,
    output logic        EN_pc,
    output logic        EN_ifid,
    output logic        EN_idex,
    output logic        flush_ifid,
    output logic        bb_data,
    output logic        bb_bj,
    output logic        mdu_busy,
    output logic        halted,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MDU_BUSY = 2'd1,
        HALT     = 2'd2
    } state_t;

    localparam logic [7:0] MUL_LOAD = 8'(MUL_LAT - 1);
    localparam logic [7:0] DIV_LOAD = 8'(DIV_LAT - 1);

    state_t     r_state;
    state_t     w_state_next;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_next;
    logic       w_load_use;
    logic       w_hilo_stall;

    assign w_load_use = RegWrite_ex & MemtoReg_ex & (WbRegNum_ex != 5'd0) &
                        ((use_rs & (rs_id == WbRegNum_ex)) | (use_rt & (rt_id == WbRegNum_ex)));
    assign w_hilo_stall = (r_state == MDU_BUSY) & hilo_id;

    assign mdu_busy = (r_state == MDU_BUSY);
    assign halted   = (r_state == HALT);

    always_ff @(posedge clk) begin
        if (CLR) begin
            r_state <= RUN;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        EN_pc        = 1'b1;
        EN_ifid      = 1'b1;
        EN_idex      = 1'b1;
        flush_ifid   = 1'b0;
        bb_data      = 1'b0;
        bb_bj        = 1'b0;

        case (r_state)
            RUN: begin
                if (mdu_start) begin
                    w_state_next = MDU_BUSY;
                    w_cnt_next   = mdu_div ? DIV_LOAD : MUL_LOAD;
                end
            end
            MDU_BUSY: begin
                // Counter is loaded with LAT-1, so leaving on zero gives exactly LAT busy cycles.
                if (r_cnt == 8'd0) begin
                    w_state_next = RUN;
                end else begin
                    w_cnt_next = r_cnt - 8'd1;
                end
            end
            HALT: begin
                EN_pc   = 1'b0;
                EN_ifid = 1'b0;
                EN_idex = 1'b0;
            end
            default: w_state_next = RUN;
        endcase

        if (r_state != HALT) begin
            if (SYSCALL_wb) begin
                w_state_next = HALT;
            end
            // A taken branch squashes the younger instruction, so any stall it would cause is moot.
            if (bj_taken) begin
                flush_ifid = 1'b1;
                bb_bj      = 1'b1;
                EN_idex    = 1'b0;
            end else if (w_load_use | w_hilo_stall) begin
                EN_pc   = 1'b0;
                EN_ifid = 1'b0;
                EN_idex = 1'b0;
                bb_data = 1'b1;
            end
        end
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    always_ff @(posedge clk) begin
        if (CLR) begin
            r_stall_cnt <= 32'd0;
            r_flush_cnt <= 32'd0;
        end else if (r_state != HALT) begin
            if (bb_data) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (flush_ifid) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`else
    assign stall_cnt = 32'd0;
    assign flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized bench for hazard_ctrl against a cycle-count reference model of the hazard rules.
module tb_hazard_ctrl;

    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 32;

    logic        clk = 1'b0;
    logic        CLR;
    logic [4:0]  rs_id, rt_id, WbRegNum_ex;
    logic        use_rs, use_rt, hilo_id, RegWrite_ex, MemtoReg_ex;
    logic        bj_taken, mdu_start, mdu_div, SYSCALL_wb;
    logic        EN_pc, EN_ifid, EN_idex, flush_ifid, bb_data, bb_bj, mdu_busy, halted;
    logic [31:0] stall_cnt, flush_cnt;

    always #5 clk = ~clk;

    hazard_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk(clk), .CLR(CLR), .rs_id(rs_id), .rt_id(rt_id), .use_rs(use_rs), .use_rt(use_rt),
        .hilo_id(hilo_id), .RegWrite_ex(RegWrite_ex), .MemtoReg_ex(MemtoReg_ex),
        .WbRegNum_ex(WbRegNum_ex), .bj_taken(bj_taken), .mdu_start(mdu_start),
        .mdu_div(mdu_div), .SYSCALL_wb(SYSCALL_wb), .EN_pc(EN_pc), .EN_ifid(EN_ifid),
        .EN_idex(EN_idex), .flush_ifid(flush_ifid), .bb_data(bb_data), .bb_bj(bb_bj),
        .mdu_busy(mdu_busy), .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: remaining busy cycles, halt flag, event tallies.
    int          m_busy_left = 0;
    bit          m_halted    = 1'b0;
    logic [31:0] m_stalls    = 32'd0;
    logic [31:0] m_flushes   = 32'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic idle();
        CLR = 0; rs_id = 0; rt_id = 0; WbRegNum_ex = 0; use_rs = 0; use_rt = 0;
        hilo_id = 0; RegWrite_ex = 0; MemtoReg_ex = 0; bj_taken = 0;
        mdu_start = 0; mdu_div = 0; SYSCALL_wb = 0;
    endtask

    // Check the current cycle's outputs against the model, then advance one clock.
    task automatic tick(input string tag);
        bit lu, busy, stall, e_pc, e_ifid, e_idex, e_fl, e_bbd, e_bbb;
        logic [31:0] e_sc, e_fc;
        #2;
        lu = RegWrite_ex && MemtoReg_ex && (WbRegNum_ex != 0) &&
             ((use_rs && rs_id == WbRegNum_ex) || (use_rt && rt_id == WbRegNum_ex));
        busy  = !m_halted && (m_busy_left > 0);
        stall = lu || (busy && hilo_id);
        e_fl = 0; e_bbd = 0; e_bbb = 0;
        if (m_halted) begin
            e_pc = 0; e_ifid = 0; e_idex = 0;
        end else if (bj_taken) begin
            e_pc = 1; e_ifid = 1; e_idex = 0; e_fl = 1; e_bbb = 1;
        end else if (stall) begin
            e_pc = 0; e_ifid = 0; e_idex = 0; e_bbd = 1;
        end else begin
            e_pc = 1; e_ifid = 1; e_idex = 1;
        end
`ifdef HAZARD_STATS_EN
        e_sc = m_stalls; e_fc = m_flushes;
`else
        e_sc = 32'd0; e_fc = 32'd0;
`endif
        check({tag, ".EN_pc"}, EN_pc, e_pc);
        check({tag, ".EN_ifid"}, EN_ifid, e_ifid);
        check({tag, ".EN_idex"}, EN_idex, e_idex);
        check({tag, ".flush_ifid"}, flush_ifid, e_fl);
        check({tag, ".bb_data"}, bb_data, e_bbd);
        check({tag, ".bb_bj"}, bb_bj, e_bbb);
        check({tag, ".mdu_busy"}, mdu_busy, busy);
        check({tag, ".halted"}, halted, m_halted);
        check({tag, ".stall_cnt"}, stall_cnt, e_sc);
        check({tag, ".flush_cnt"}, flush_cnt, e_fc);
        @(posedge clk);
        if (CLR) begin
            m_busy_left = 0; m_halted = 0; m_stalls = 0; m_flushes = 0;
        end else if (!m_halted) begin
            if (e_bbd) m_stalls++;
            if (e_fl) m_flushes++;
            if (m_busy_left > 0) m_busy_left--;
            else if (mdu_start) m_busy_left = mdu_div ? DIV_LAT : MUL_LAT;
            if (SYSCALL_wb) begin
                m_halted = 1; m_busy_left = 0;
            end
        end
        #1;
    endtask

    task automatic load_use_r5();
        RegWrite_ex = 1; MemtoReg_ex = 1; WbRegNum_ex = 5; use_rs = 1; rs_id = 5;
    endtask

    initial begin
        idle();
        CLR = 1;
        repeat (2) @(posedge clk);
        #1;
        idle();
        tick("reset");

        // Load-use on r5, then the same pattern targeting r0.
        load_use_r5(); tick("lu_r5");
        idle(); use_rt = 1; rt_id = 5; RegWrite_ex = 1; MemtoReg_ex = 1; WbRegNum_ex = 5; tick("lu_rt");
        idle(); load_use_r5(); WbRegNum_ex = 0; rs_id = 0; tick("lu_r0");
        idle(); load_use_r5(); MemtoReg_ex = 0; tick("alu_fwd");

        // Branch while a load-use is pending.
        idle(); load_use_r5(); bj_taken = 1; tick("bj_lu");
        idle(); bj_taken = 1; tick("bj_only");
        idle(); tick("idle");

        // Divide occupancy with HI/LO access at T+10 and T+33.
        idle(); mdu_start = 1; mdu_div = 1; tick("div_start");
        for (int k = 1; k <= DIV_LAT + 1; k++) begin
            idle();
            if (k == 10 || k == DIV_LAT + 1) hilo_id = 1;
            if (k == 5) begin mdu_start = 1; mdu_div = 0; end
            tick($sformatf("div_t%0d", k));
        end

        // Multiply, then halt while busy, then clear.
        idle(); mdu_start = 1; tick("mul_start");
        idle(); SYSCALL_wb = 1; hilo_id = 1; tick("syscall");
        for (int k = 0; k < 20; k++) begin
            idle(); load_use_r5(); if (k % 3 == 0) bj_taken = 1; mdu_start = 1;
            tick($sformatf("halt_%0d", k));
        end
        idle(); SYSCALL_wb = 1; CLR = 1; tick("clr");
        idle(); tick("post_clr");

        // Three load-use stalls and two branch flushes from a cleared state.
        idle(); CLR = 1; tick("stats_clr");
        for (int k = 0; k < 3; k++) begin idle(); load_use_r5(); tick("stats_lu"); end
        for (int k = 0; k < 2; k++) begin idle(); bj_taken = 1; tick("stats_bj"); end
        idle(); tick("stats_end");

        for (int k = 0; k < 3000; k++) begin
            CLR         = ($urandom_range(0, 99) == 0);
            SYSCALL_wb  = ($urandom_range(0, 149) == 0);
            rs_id       = 5'($urandom_range(0, 3));
            rt_id       = 5'($urandom_range(0, 3));
            WbRegNum_ex = 5'($urandom_range(0, 3));
            use_rs      = 1'($urandom);
            use_rt      = 1'($urandom);
            RegWrite_ex = 1'($urandom);
            MemtoReg_ex = 1'($urandom);
            hilo_id     = ($urandom_range(0, 3) == 0);
            bj_taken    = ($urandom_range(0, 5) == 0);
            mdu_start   = ($urandom_range(0, 7) == 0);
            mdu_div     = ($urandom_range(0, 3) == 0);
            tick("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
